// File: rtl/sdram_controller.sv
// Single-port SDRAM controller: power-up init, periodic auto-refresh and
// closed-page single-word reads/writes with auto-precharge.
module sdram_controller #(
  parameter int INIT_WAIT        = 5000,
  parameter int REFRESH_INTERVAL = 390,
  parameter int CAS_LATENCY      = 2,
  parameter int T_RCD            = 1,
  parameter int T_RP             = 1,
  parameter int T_WR             = 2,
  parameter int T_MRD            = 2,
  parameter int T_RFC            = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [22:0] wr_addr,
  input  logic [15:0] wr_data,
  input  logic        wr_enable,
  input  logic [22:0] rd_addr,
  input  logic        rd_enable,
  output logic [15:0] rd_data,
  output logic        rd_ready,
  output logic        busy,
  output logic [11:0] addr,
  output logic [1:0]  bank_addr,
  inout  wire  [15:0] data,
  output logic        clock_enable,
  output logic        cs_n,
  output logic        ras_n,
  output logic        cas_n,
  output logic        we_n,
  output logic        data_mask_low,
  output logic        data_mask_high
);

  localparam logic [3:0] S_INIT_WAIT = 4'd0,  S_INIT_PRE  = 4'd1,  S_INIT_REF1 = 4'd2,
                         S_INIT_REF2 = 4'd3,  S_INIT_MRS  = 4'd4,  S_IDLE      = 4'd5,
                         S_REFRESH   = 4'd6,  S_ACTIVATE  = 4'd7,  S_WRITE     = 4'd8,
                         S_READ      = 4'd9,  S_READ_WAIT = 4'd10, S_DONE      = 4'd11;

  localparam logic [3:0] CMD_NOP = 4'b0111, CMD_ACT = 4'b0011, CMD_RD  = 4'b0101,
                         CMD_WR  = 4'b0100, CMD_PRE = 4'b0010, CMD_REF = 4'b0001,
                         CMD_MRS = 4'b0000;

  localparam int CW = $clog2(INIT_WAIT + T_WR + T_RP + T_RFC + T_MRD + T_RCD + CAS_LATENCY + 2) + 1;
  localparam int RW = $clog2(REFRESH_INTERVAL + 1);

  logic [3:0]    state;
  logic [3:0]    cmd;
  logic [CW-1:0] cnt, dur;
  logic          last;
  logic [RW-1:0] ref_cnt;
  logic          ref_pend, init_done, lat_wr, dq_oe, dm;
  logic [22:0]   lat_addr;
  logic [15:0]   dq_out;

  // Cycles spent in each state, counted from the cycle its command is on the pins.
  // INIT_WAIT gets one extra: the first edge out of reset only raises clock_enable.
  always_comb begin
    dur = CW'(1);
    case (state)
      S_INIT_WAIT:                        dur = CW'(INIT_WAIT + 1);
      S_INIT_PRE:                         dur = CW'(T_RP);
      S_INIT_REF1, S_INIT_REF2, S_REFRESH: dur = CW'(T_RFC);
      S_INIT_MRS:                         dur = CW'(T_MRD);
      S_ACTIVATE:                         dur = CW'(T_RCD);
      S_WRITE:                            dur = CW'(T_WR + T_RP);
      S_READ_WAIT:                        dur = CW'(CAS_LATENCY);
      S_DONE:                             dur = CW'(T_RP);
      default:                            dur = CW'(1);
    endcase
  end

  assign last = (cnt == dur - CW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_INIT_WAIT;
      cmd          <= 4'b1111;
      cnt          <= '0;
      ref_cnt      <= '0;
      ref_pend     <= 1'b0;
      init_done    <= 1'b0;
      lat_wr       <= 1'b0;
      lat_addr     <= '0;
      dq_out       <= '0;
      dq_oe        <= 1'b0;
      dm           <= 1'b1;
      clock_enable <= 1'b0;
      addr         <= '0;
      bank_addr    <= '0;
      rd_data      <= '0;
      rd_ready     <= 1'b0;
    end else begin
      cmd          <= CMD_NOP;
      dq_oe        <= 1'b0;
      rd_ready     <= 1'b0;
      clock_enable <= 1'b1;
      cnt          <= last ? '0 : cnt + CW'(1);
      case (state)
        S_INIT_WAIT: if (last) begin
          state <= S_INIT_PRE; cmd <= CMD_PRE; addr <= 12'h400; bank_addr <= 2'd0;
        end
        S_INIT_PRE:  if (last) begin state <= S_INIT_REF1; cmd <= CMD_REF; end
        S_INIT_REF1: if (last) begin state <= S_INIT_REF2; cmd <= CMD_REF; end
        S_INIT_REF2: if (last) begin
          state <= S_INIT_MRS; cmd <= CMD_MRS; addr <= 12'h020; bank_addr <= 2'd0;
        end
        S_INIT_MRS:  if (last) begin state <= S_IDLE; dm <= 1'b0; init_done <= 1'b1; end
        S_IDLE: begin
          if (ref_pend) begin
            state <= S_REFRESH; cmd <= CMD_REF; ref_pend <= 1'b0;
          end else if (wr_enable) begin
            state <= S_ACTIVATE; cmd <= CMD_ACT; lat_wr <= 1'b1;
            lat_addr <= wr_addr; dq_out <= wr_data;
            addr <= wr_addr[20:9]; bank_addr <= wr_addr[22:21];
          end else if (rd_enable) begin
            state <= S_ACTIVATE; cmd <= CMD_ACT; lat_wr <= 1'b0;
            lat_addr <= rd_addr;
            addr <= rd_addr[20:9]; bank_addr <= rd_addr[22:21];
          end
        end
        S_REFRESH:   if (last) state <= S_IDLE;
        // Column command with A10 set so the bank closes itself.
        S_ACTIVATE:  if (last) begin
          state <= lat_wr ? S_WRITE : S_READ;
          cmd   <= lat_wr ? CMD_WR : CMD_RD;
          addr  <= {1'b0, 1'b1, 1'b0, lat_addr[8:0]};
          dq_oe <= lat_wr;
        end
        S_WRITE:     if (last) state <= S_IDLE;
        S_READ:      state <= S_READ_WAIT;
        S_READ_WAIT: if (last) begin
          state <= S_DONE; rd_data <= data; rd_ready <= 1'b1;
        end
        S_DONE:      if (last) state <= S_IDLE;
        default:     state <= S_INIT_WAIT;
      endcase
      // Placed after the FSM so a wrap on the issuing edge is never lost.
      if (init_done) begin
        if (ref_cnt == RW'(REFRESH_INTERVAL - 1)) begin
          ref_cnt <= '0; ref_pend <= 1'b1;
        end else begin
          ref_cnt <= ref_cnt + RW'(1);
        end
      end
    end
  end

  assign {cs_n, ras_n, cas_n, we_n} = cmd;
  assign data           = dq_oe ? dq_out : 16'bz;
  assign data_mask_low  = dm;
  assign data_mask_high = dm;
  assign busy           = (state != S_IDLE);

endmodule

// File: tb/tb_sdram_controller.sv
// Bench for sdram_controller: behavioural SDRAM device on the pins plus a
// word-addressed reference memory; random and directed accesses.
module tb_sdram_controller;
  localparam int IW = 40, RI = 100, CL = 2, T_RCD = 1, T_RP = 1, T_WR = 2, T_MRD = 2, T_RFC = 4;
  localparam logic [3:0] C_NOP = 4'b0111, C_ACT = 4'b0011, C_RD = 4'b0101, C_WR = 4'b0100,
                         C_PRE = 4'b0010, C_REF = 4'b0001, C_MRS = 4'b0000;

  logic clk = 1'b0, rst_n;
  logic [22:0] wr_addr, rd_addr;
  logic [15:0] wr_data, rd_data;
  logic wr_enable, rd_enable, rd_ready, busy;
  logic [11:0] addr;
  logic [1:0] bank_addr;
  wire  [15:0] data;
  logic clock_enable, cs_n, ras_n, cas_n, we_n, data_mask_low, data_mask_high;

  sdram_controller #(.INIT_WAIT(IW), .REFRESH_INTERVAL(RI)) dut (
    .clk(clk), .rst_n(rst_n), .wr_addr(wr_addr), .wr_data(wr_data), .wr_enable(wr_enable),
    .rd_addr(rd_addr), .rd_enable(rd_enable), .rd_data(rd_data), .rd_ready(rd_ready),
    .busy(busy), .addr(addr), .bank_addr(bank_addr), .data(data),
    .clock_enable(clock_enable), .cs_n(cs_n), .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n),
    .data_mask_low(data_mask_low), .data_mask_high(data_mask_high));

  always #10 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0, b0 = 0, zviol = 0;
  logic post_init = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Pin monitor and SDRAM device model
  typedef struct { logic [3:0] cmd; logic [11:0] a; logic [1:0] ba; int cyc; logic [15:0] dq; } ev_t;
  typedef struct { int cyc; logic [15:0] d; } rd_t;
  ev_t cq[$];
  rd_t rq[$];
  logic [15:0] mmem [logic [22:0]];
  logic [11:0] open_row [4];
  logic [15:0] mdq = '0;
  logic        mdrv = 1'b0;
  logic [22:0] rkey;
  wire  [3:0]  pin_cmd = {cs_n, ras_n, cas_n, we_n};
  assign data = mdrv ? mdq : 16'bz;

  always @(negedge clk) begin
    if (rst_n && pin_cmd != C_NOP && pin_cmd != 4'b1111)
      cq.push_back('{pin_cmd, addr, bank_addr, cyc, data});
    if (pin_cmd == C_ACT) open_row[bank_addr] = addr;
    if (pin_cmd == C_WR) mmem[{bank_addr, open_row[bank_addr], addr[8:0]}] = data;
    if (rd_ready) rq.push_back('{cyc, rd_data});
    if (pin_cmd != C_WR && !mdrv && data !== 16'hzzzz) zviol++;
    if (post_init && rst_n && pin_cmd == C_REF) chk("ref_phase", (cyc - b0 - 1) % RI, 0);
  end

  always @(negedge clk) begin
    if (rst_n && pin_cmd == C_RD) begin
      rkey = {bank_addr, open_row[bank_addr], addr[8:0]};
      repeat (CL) @(posedge clk);
      #2 mdq = mmem.exists(rkey) ? mmem[rkey] : 16'hDEAD;
      mdrv = 1'b1;
      @(posedge clk);
      #2 mdrv = 1'b0;
    end
  end

  // Reference model: word memory indexed by the logical address
  logic [15:0] ref_mem [logic [22:0]];
  logic [22:0] addrs[$];
  logic [15:0] last_rd = '0;

  function automatic logic phase_ok(input int a);
    int p = (a - b0) % RI;
    return p >= 5 && p <= RI - 20;
  endfunction

  task automatic wait_safe();
    int n = 0;
    @(negedge clk);
    while ((busy || !phase_ok(cyc + 1)) && n < 500) begin @(negedge clk); n++; end
    if (n >= 500) chk("safe_timeout", 1, 0);
    #1;
  endtask

  task automatic wait_idle(output int fc);
    int n = 0;
    while (busy && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk("idle_timeout", 1, 0);
    fc = cyc;
  endtask

  task automatic check_init();
    int k, fc;
    cq.delete();
    rst_n = 1'b1;
    @(posedge clk); #1 k = cyc;
    chk("busy_init", busy, 1);
    chk("dm_init", {data_mask_high, data_mask_low}, 2'b11);
    @(negedge clk);
    begin
      int n = 0;
      while (busy && n < IW + 100) begin @(negedge clk); n++; end
      if (n >= IW + 100) chk("init_timeout", 1, 0);
    end
    fc = cyc;
    chk("init_ncmd", cq.size(), 4);
    if (cq.size() == 4) begin
      chk("pre_cmd", cq[0].cmd, C_PRE);   chk("pre_a10", cq[0].a[10], 1);
      chk("pre_cyc", cq[0].cyc - k, IW);
      chk("ref1_cmd", cq[1].cmd, C_REF);  chk("ref1_cyc", cq[1].cyc - cq[0].cyc, T_RP);
      chk("ref2_cmd", cq[2].cmd, C_REF);  chk("ref2_cyc", cq[2].cyc - cq[1].cyc, T_RFC);
      chk("mrs_cmd", cq[3].cmd, C_MRS);   chk("mrs_cyc", cq[3].cyc - cq[2].cyc, T_RFC);
      chk("mrs_addr", cq[3].a, 12'h020);  chk("mrs_ba", cq[3].ba, 0);
      chk("mrs_done", fc - cq[3].cyc, T_MRD);
    end
    chk("dm_run", {data_mask_high, data_mask_low}, 2'b00);
    chk("cke_run", clock_enable, 1);
    b0 = fc;
    post_init = 1'b1;
  endtask

  task automatic do_write(input logic [22:0] a, input logic [15:0] d);
    int acc, fc;
    wait_safe();
    cq.delete(); rq.delete();
    wr_addr = a; wr_data = d; wr_enable = 1'b1; acc = cyc + 1;
    @(negedge clk); wr_enable = 1'b0;
    wait_idle(fc);
    chk("wr_ncmd", cq.size(), 2);
    if (cq.size() == 2) begin
      chk("wact_cmd", cq[0].cmd, C_ACT);  chk("wact_cyc", cq[0].cyc, acc);
      chk("wact_row", cq[0].a, a[20:9]);  chk("wact_ba", cq[0].ba, a[22:21]);
      chk("wr_cmd", cq[1].cmd, C_WR);     chk("wr_rcd", cq[1].cyc - cq[0].cyc, T_RCD);
      chk("wr_col", cq[1].a, 12'h400 | {3'b0, a[8:0]});
      chk("wr_ba", cq[1].ba, a[22:21]);   chk("wr_dq", cq[1].dq, d);
      chk("wr_done", fc - cq[1].cyc, T_WR + T_RP);
    end
    chk("wr_nrdy", rq.size(), 0);
    if (!ref_mem.exists(a)) addrs.push_back(a);
    ref_mem[a] = d;
  endtask

  task automatic do_read(input logic [22:0] a);
    int acc, fc;
    wait_safe();
    cq.delete(); rq.delete();
    rd_addr = a; rd_enable = 1'b1; acc = cyc + 1;
    @(negedge clk); rd_enable = 1'b0;
    wait_idle(fc);
    last_rd = ref_mem[a];
    chk("rd_ncmd", cq.size(), 2);
    if (cq.size() == 2) begin
      chk("ract_cmd", cq[0].cmd, C_ACT);  chk("ract_cyc", cq[0].cyc, acc);
      chk("ract_row", cq[0].a, a[20:9]);  chk("ract_ba", cq[0].ba, a[22:21]);
      chk("rd_cmd", cq[1].cmd, C_RD);     chk("rd_rcd", cq[1].cyc - cq[0].cyc, T_RCD);
      chk("rd_col", cq[1].a, 12'h400 | {3'b0, a[8:0]});
      chk("rd_done", fc - cq[1].cyc, 1 + CL + T_RP);
      chk("rd_nrdy", rq.size(), 1);
      if (rq.size() == 1) begin
        chk("rdy_cyc", rq[0].cyc - cq[1].cyc, 1 + CL);
        chk("rd_data", rq[0].d, last_rd);
      end
    end
    chk("rd_hold", rd_data, last_rd);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; wr_enable = 1'b0; rd_enable = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_data = '0;
    #50;
    chk("rst_busy", busy, 1);          chk("rst_cmd", pin_cmd, 4'hF);
    chk("rst_cke", clock_enable, 0);   chk("rst_addr", {bank_addr, addr}, 0);
    chk("rst_dm", {data_mask_high, data_mask_low}, 2'b11);
    chk("rst_rdy", rd_ready, 0);       chk("rst_rdata", rd_data, 0);
    chk("rst_hiz", data === 16'hzzzz, 1);
    #50;
    check_init();

    do_write(23'd0, 16'h5555);
    do_read(23'd0);
    do_write({2'd3, 12'hFFF, 9'h1FF}, 16'hABCD);
    do_read({2'd3, 12'hFFF, 9'h1FF});

    for (int i = 0; i < 16; i++) begin
      if (addrs.size() == 0 || $urandom_range(0, 1) == 0) begin
        logic [22:0] a;
        a = ($urandom_range(0, 3) == 0) ? addrs[$urandom_range(0, addrs.size() - 1)] : 23'($urandom);
        do_write(a, 16'($urandom));
      end else begin
        do_read(addrs[$urandom_range(0, addrs.size() - 1)]);
      end
    end

    // Simultaneous write+read, then a read while busy: only the write runs
    begin
      int fc;
      logic [22:0] wa;
      logic [15:0] wd;
      wa = {2'd1, 12'h123, 9'h045}; wd = 16'h3C5A;
      wait_safe();
      cq.delete(); rq.delete();
      wr_addr = wa; wr_data = wd; rd_addr = {2'd2, 12'h0AA, 9'h011};
      wr_enable = 1'b1; rd_enable = 1'b1;
      @(negedge clk); wr_enable = 1'b0;
      @(negedge clk); rd_enable = 1'b0;
      wait_idle(fc);
      repeat (10) @(negedge clk);
      chk("dual_ncmd", cq.size(), 2);
      if (cq.size() == 2) begin
        chk("dual_wr", cq[1].cmd, C_WR);
        chk("dual_dq", cq[1].dq, wd);
      end
      chk("dual_nrdy", rq.size(), 0);
      chk("dual_hold", rd_data, last_rd);
      if (!ref_mem.exists(wa)) addrs.push_back(wa);
      ref_mem[wa] = wd;
      do_read(wa);
    end

    // Idle window: exactly three refreshes at RI spacing
    begin
      int nref = 0, nother = 0;
      @(negedge clk); #1 cq.delete();
      repeat (3 * RI) @(negedge clk);
      #1;
      foreach (cq[i]) if (cq[i].cmd == C_REF) nref++; else nother++;
      chk("idle_nref", nref, 3);
      chk("idle_nother", nother, 0);
      if (cq.size() == 3) begin
        chk("idle_sp1", cq[1].cyc - cq[0].cyc, RI);
        chk("idle_sp2", cq[2].cyc - cq[1].cyc, RI);
      end
    end

    // Reset in the middle of a read
    begin
      int n = 0;
      wait_safe();
      cq.delete(); rq.delete();
      rd_addr = 23'd0; rd_enable = 1'b1;
      @(negedge clk); rd_enable = 1'b0;
      while (cq.size() < 2 && n < 20) begin @(negedge clk); #1; n++; end
      chk("mid_rd_seen", (cq.size() >= 2) ? cq[cq.size() - 1].cmd : 4'hF, C_RD);
      @(negedge clk);
      post_init = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("mid_busy", busy, 1);          chk("mid_cmd", pin_cmd, 4'hF);
      chk("mid_cke", clock_enable, 0);   chk("mid_addr", {bank_addr, addr}, 0);
      chk("mid_dm", {data_mask_high, data_mask_low}, 2'b11);
      chk("mid_rdy", rd_ready, 0);       chk("mid_rdata", rd_data, 0);
      chk("mid_hiz", data === 16'hzzzz, 1);
      repeat (5) @(negedge clk);
      chk("mid_nrdy", rq.size(), 0);
      check_init();
      do_write({2'd2, 12'h00F, 9'h100}, 16'h0F0F);
      do_read({2'd2, 12'h00F, 9'h100});
    end

    chk("dq_hiz", zviol, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sdram_controller.md
SDRAM_CONTROLLER -- requirements
Module: sdram_controller

Interface
REQ-001 SHALL have parameters: INIT_WAIT=5000 (power-up wait in clocks, 100 us at 50 MHz); REFRESH_INTERVAL=390 (clocks between auto-refreshes); CAS_LATENCY=2; T_RCD=1, T_RP=1, T_WR=2, T_MRD=2, T_RFC=4 (clocks).
REQ-002 clk  in  1  controller and SDRAM clock, 50 MHz nominal.
REQ-003 rst_n  in  1  reset; one clock, asynchronous, active-low.
REQ-004 wr_addr  in  23  write word address: bank=[22:21], row=[20:9], column=[8:0].
REQ-005 wr_data  in  16  write data.
REQ-006 wr_enable  in  1  one-cycle write request.
REQ-007 rd_addr  in  23  read word address, same mapping as wr_addr.
REQ-008 rd_enable  in  1  one-cycle read request.
REQ-009 rd_data  out  16  read data, registered.
REQ-010 rd_ready  out  1  one-cycle pulse; rd_data is valid.
REQ-011 busy  out  1  high whenever the controller is not in IDLE.
REQ-012 addr  out  12  SDRAM A[11:0]; bank_addr  out  2  SDRAM BA.
REQ-013 data  inout  16  SDRAM DQ; high-Z except in the WRITE command cycle.
REQ-014 clock_enable, cs_n, ras_n, cas_n, we_n, data_mask_low, data_mask_high  out  1 each  SDRAM control pins, all registered.

Function
REQ-015 Commands (cs_n,ras_n,cas_n,we_n): NOP 0111, ACTIVE 0011, READ 0101, WRITE 0100, PRECHARGE 0010, AUTO-REFRESH 0001, LOAD MODE 0000.
REQ-016 States: INIT_WAIT, INIT_PRE, INIT_REF1, INIT_REF2, INIT_MRS, IDLE, REFRESH, ACTIVATE, WRITE, READ, READ_WAIT, DONE; every state not issuing a command SHALL issue NOP.
REQ-017 Init sequence:
- INIT_WAIT for INIT_WAIT clocks, clock_enable=1;
- PRECHARGE ALL (A10=1), wait T_RP;
- two AUTO-REFRESH, each followed by T_RFC;
- LOAD MODE with addr=12'h020 (burst length 1, sequential, CL2, programmed burst write) and bank_addr=0, wait T_MRD;
- go to IDLE.
REQ-018 data_mask_low/high SHALL be 1 until INIT_MRS completes and 0 afterwards.
REQ-019 In IDLE the priority SHALL be: refresh due > wr_enable > rd_enable; the chosen request is latched (address/data) on the accepting edge, and busy rises the next cycle.
REQ-020 wr_enable/rd_enable asserted while busy=1 SHALL be ignored, not queued.
REQ-021 Access policy is closed-page:
- ACTIVATE (bank, row) one cycle after acceptance;
- after T_RCD, READ or WRITE with column on addr[8:0] and A10=1 (auto-precharge).
REQ-022 Write: data SHALL be driven only in the WRITE command cycle; then wait T_WR+T_RP before IDLE.
REQ-023 Read: DQ SHALL be sampled CAS_LATENCY clocks after the READ edge into rd_data; rd_ready SHALL pulse high for exactly the next cycle; wait T_RP before IDLE.
REQ-024 rd_data SHALL hold its value until the next read completes.
REQ-025 Refresh counter:
- counts clocks from leaving init; at REFRESH_INTERVAL, sets refresh pending and restarts;
- pending is serviced in IDLE (AUTO-REFRESH, T_RFC wait) and cleared when the refresh issues;
- a refresh falling due during an access is deferred until that access returns to IDLE.
REQ-026 Same-cycle wr_enable and rd_enable in IDLE: the write is performed and the read is dropped.

Reset
REQ-027 While rst_n=0 (asserted at any time, including mid-access):
- state=INIT_WAIT, counters=0, refresh pending cleared;
- cs_n=1, ras_n=cas_n=we_n=1, clock_enable=0, addr=0, bank_addr=0, data_mask_low/high=1, data high-Z;
- rd_data=0, rd_ready=0, busy=1.
REQ-028 Release of rst_n SHALL restart the full init sequence.

Verification
REQ-029 Release reset at 100 ns -> busy=1; after INIT_WAIT: PRECHARGE with A10=1, 2x AUTO-REFRESH, LOAD MODE addr=0x020; then busy=0.
REQ-030 After init, write 0x5555 to address 0, then read address 0 -> ACTIVE row 0 / bank 0, WRITE with A10=1, then READ; rd_ready pulses once with rd_data=0x5555.
REQ-031 Write 0xABCD to {bank 3, row 0xFFF, col 0x1FF} and read it back -> bank_addr=3, addr=0xFFF on ACTIVE, column 0x1FF on READ; rd_data=0xABCD.
REQ-032 Idle for 3xREFRESH_INTERVAL -> exactly 3 AUTO-REFRESH commands at REFRESH_INTERVAL spacing.
REQ-033 wr_enable and rd_enable in the same cycle, then a second rd_enable while busy -> only the write executes; no rd_ready.
REQ-034 Assert rst_n=0 during READ_WAIT -> outputs at reset values at once, no rd_ready; after release, full init repeats.
